// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - bus-programmed static LEDs plus two RGB LEDs with shadowed PWM dimming
module led_pwm_ctrl #(
  parameter int PRESCALE_W = 16,
  parameter int DUTY_W     = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  leds,
  output logic [2:0]  rgb_led_ld4,
  output logic [2:0]  rgb_led_ld5,
  output logic        period_start
);

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_PRESCALE = 4'd1;
  localparam logic [3:0] A_LEDS     = 4'd2;
  localparam logic [3:0] A_LD4      = 4'd3;
  localparam logic [3:0] A_LD5      = 4'd4;
  localparam logic [3:0] A_STATUS   = 4'd5;
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic                       en_q, en_d;
  logic [PRESCALE_W-1:0]      prescale_q, prescale_d;
  logic [3:0]                 leds_reg_q, leds_reg_d;
  logic [2:0][DUTY_W-1:0]     ld4_q, ld4_d, ld5_q, ld5_d;
  logic [2:0][DUTY_W-1:0]     sh4_q, sh4_d, sh5_q, sh5_d;
  logic [PRESCALE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [31:0]                rsp_rdata_q, rsp_rdata_d;
  logic [3:0]                 leds_q, leds_d;
  logic [2:0]                 ld4_out_q, ld4_out_d, ld5_out_q, ld5_out_d;
  logic                       period_start_q, period_start_d;

  logic        accept;
  logic        wr_en;
  logic        run;
  logic        tick;
  logic        wrap;
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (req_addr)
      A_CTRL:     rd_data[0] = en_q;
      A_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale_q;
      A_LEDS:     rd_data[3:0] = leds_reg_q;
      A_LD4:      for (int i = 0; i < 3; i++) rd_data[8*i +: DUTY_W] = ld4_q[i];
      A_LD5:      for (int i = 0; i < 3; i++) rd_data[8*i +: DUTY_W] = ld5_q[i];
      A_STATUS:   rd_data[DUTY_W-1:0] = pwm_cnt_q;
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    accept     = req_valid && !rsp_valid_q;
    wr_en      = accept && req_write;
    en_d       = en_q;
    prescale_d = prescale_q;
    leds_reg_d = leds_reg_q;
    ld4_d      = ld4_q;
    ld5_d      = ld5_q;
    if (wr_en) begin
      case (req_addr)
        A_CTRL:     en_d = req_wdata[0];
        A_PRESCALE: prescale_d = req_wdata[PRESCALE_W-1:0];
        A_LEDS:     leds_reg_d = req_wdata[3:0];
        A_LD4:      for (int i = 0; i < 3; i++) ld4_d[i] = req_wdata[8*i +: DUTY_W];
        A_LD5:      for (int i = 0; i < 3; i++) ld5_d[i] = req_wdata[8*i +: DUTY_W];
        default:    ;
      endcase
    end

    rsp_valid_d = accept;
    rsp_rdata_d = (accept && !req_write) ? rd_data : '0;

    // A disabling write stops the counters on its own edge so STATUS never shows a stray step
    run       = en_q && en_d;
    tick      = run && (pre_cnt_q == prescale_q);
    wrap      = tick && (pwm_cnt_q == CNT_MAX);
    pre_cnt_d = '0;
    pwm_cnt_d = '0;
    if (run) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
      pwm_cnt_d = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
      if (wr_en && (req_addr == A_PRESCALE)) pre_cnt_d = '0;
    end

    // Shadows take the pre-edge duty, so a write landing on the wrap waits a full period
    sh4_d = sh4_q;
    sh5_d = sh5_q;
    if (!en_q || wrap) begin
      sh4_d = ld4_q;
      sh5_d = ld5_q;
    end

    for (int i = 0; i < 3; i++) begin
      ld4_out_d[i] = en_q && (pwm_cnt_q < sh4_q[i]);
      ld5_out_d[i] = en_q && (pwm_cnt_q < sh5_q[i]);
    end
    leds_d         = en_q ? leds_reg_q : '0;
    period_start_d = wrap;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      en_q           <= 1'b0;
      prescale_q     <= '0;
      leds_reg_q     <= '0;
      ld4_q          <= '0;
      ld5_q          <= '0;
      sh4_q          <= '0;
      sh5_q          <= '0;
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      leds_q         <= '0;
      ld4_out_q      <= '0;
      ld5_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      en_q           <= en_d;
      prescale_q     <= prescale_d;
      leds_reg_q     <= leds_reg_d;
      ld4_q          <= ld4_d;
      ld5_q          <= ld5_d;
      sh4_q          <= sh4_d;
      sh5_q          <= sh5_d;
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      leds_q         <= leds_d;
      ld4_out_q      <= ld4_out_d;
      ld5_out_q      <= ld5_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign req_ready    = !rsp_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign leds         = leds_q;
  assign rgb_led_ld4  = ld4_out_q;
  assign rgb_led_ld5  = ld5_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - scoreboard bench for led_pwm_ctrl bus responses and PWM waveforms
module tb_led_pwm_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  leds;
  logic [2:0]  rgb_led_ld4;
  logic [2:0]  rgb_led_ld5;
  logic        period_start;

  led_pwm_ctrl #(.PRESCALE_W(16), .DUTY_W(8)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .leds        (leds),
    .rgb_led_ld4 (rgb_led_ld4),
    .rgb_led_ld5 (rgb_led_ld5),
    .period_start(period_start)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic        tb_en  = 1'b0;
  int          en_cyc = 0;
  int          cur_ps = 0;
  int          cnt[5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle
  task automatic bus_op(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] rexp);
    logic [31:0] e;
    bit done;
    done = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < 8 && !done; i++) begin
      if (req_ready) begin
        e = wr ? 32'h0 : rexp;
        if (!wr && a == 4'd5)
          e = tb_en ? 32'(((cyc - en_cyc) / (cur_ps + 1)) % 256) : 32'h0;
        if (wr && a == 4'd0) begin
          if (d[0] && !tb_en) en_cyc = cyc + 1;
          tb_en = d[0];
        end
        if (wr && a == 4'd1) cur_ps = int'(d[15:0]);
        exp_q.push_back(e);
        @(posedge sys_clk);
        @(negedge sys_clk);
        done = 1;
        check("rsp_latency", 32'(rsp_valid), 32'h1);
      end else begin
        @(negedge sys_clk);
      end
    end
    req_valid = 1'b0;
    check("accepted", 32'(done), 32'h1);
  endtask

  task automatic count_win(input int n);
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    for (int i = 0; i < n; i++) begin
      cnt[0] += int'(rgb_led_ld4[0]);
      cnt[1] += int'(rgb_led_ld4[2:1] != 2'b00);
      cnt[2] += int'(rgb_led_ld5[2]);
      cnt[3] += int'(rgb_led_ld5[1:0] != 2'b00);
      cnt[4] += int'(period_start);
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_ps();
    bit seen;
    seen = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge sys_clk);
      if (period_start) seen = 1;
    end
    check("ps_seen", 32'(seen), 32'h1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_leds"}, 32'(leds), 32'h0);
    check({tag, "_ld4"}, 32'(rgb_led_ld4), 32'h0);
    check({tag, "_ld5"}, 32'(rgb_led_ld5), 32'h0);
    check({tag, "_ps"}, 32'(period_start), 32'h0);
  endtask

  always @(negedge sys_clk) begin
    if (!rst && rsp_valid) begin
      check("ready_low_in_rsp", 32'(req_ready), 32'h0);
      check("rsp_expected", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] addrs[7];
    addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};

    #1 rst = 1'b1;
    #1 check_idle_outputs("reset");
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);

    foreach (addrs[i]) bus_op(1'b0, addrs[i], 32'h0, 32'h0);

    // 64/256 duty on LD4 red, prescale 0
    bus_op(1'b1, 4'd1, 32'h0, 32'h0);
    bus_op(1'b1, 4'd3, 32'h0000_0040, 32'h0);
    bus_op(1'b1, 4'd0, 32'h1, 32'h0);
    repeat (4) @(negedge sys_clk);
    count_win(256);
    check("ld4r_high_64", 32'(cnt[0]), 32'd64);
    check("ld4gb_off", 32'(cnt[1]), 32'd0);
    check("ld5_off", 32'(cnt[2] + cnt[3]), 32'd0);
    check("ps_per_256", 32'(cnt[4]), 32'd1);

    // Shadowing: mid-period write, then a write on the wrap edge
    bus_op(1'b1, 4'd3, 32'h0000_0080, 32'h0);
    wait_ps();
    wait_ps();
    fork
      count_win(256);
      begin repeat (40) @(negedge sys_clk); bus_op(1'b1, 4'd3, 32'h0000_0010, 32'h0); end
    join
    check("mid_write_keeps_128", 32'(cnt[0]), 32'd128);
    check("ps_at_boundary", 32'(period_start), 32'h1);
    fork
      count_win(256);
      begin repeat (255) @(negedge sys_clk); bus_op(1'b1, 4'd3, 32'h0000_0008, 32'h0); end
    join
    check("next_period_16", 32'(cnt[0]), 32'd16);
    check("ps_at_boundary2", 32'(period_start), 32'h1);
    count_win(256);
    check("wrap_write_deferred", 32'(cnt[0]), 32'd16);
    count_win(256);
    check("wrap_write_applied", 32'(cnt[0]), 32'd8);

    // Prescale 3, LD5 blue at full-scale duty
    bus_op(1'b1, 4'd0, 32'h0, 32'h0);
    bus_op(1'b1, 4'd1, 32'h3, 32'h0);
    bus_op(1'b1, 4'd4, 32'h00FF_0000, 32'h0);
    bus_op(1'b1, 4'd3, 32'h0000_0040, 32'h0);
    bus_op(1'b1, 4'd0, 32'h1, 32'h0);
    repeat (8) @(negedge sys_clk);
    count_win(1024);
    check("ld5b_high_1020", 32'(cnt[2]), 32'd1020);
    check("ld5rg_off", 32'(cnt[3]), 32'd0);
    check("ld4r_high_256", 32'(cnt[0]), 32'd256);
    check("ps_per_1024", 32'(cnt[4]), 32'd1);
    for (int j = 0; j < 4; j++) begin
      repeat (j * 3 + 1) @(negedge sys_clk);
      bus_op(1'b0, 4'd5, 32'h0, 32'h0);
    end
    bus_op(1'b0, 4'd4, 32'h0, 32'h00FF_0000);
    bus_op(1'b0, 4'd1, 32'h0, 32'h3);

    // Static LEDs and disable
    bus_op(1'b1, 4'd2, 32'hA, 32'h0);
    check("leds_before_latency", 32'(leds), 32'h0);
    @(negedge sys_clk);
    check("leds_on", 32'(leds), 32'hA);
    bus_op(1'b1, 4'd0, 32'h0, 32'h0);
    check("leds_hold_one_cycle", 32'(leds), 32'hA);
    @(negedge sys_clk);
    check("leds_off_disabled", 32'(leds), 32'h0);
    count_win(300);
    check("disabled_no_pwm", 32'(cnt[0] + cnt[2]), 32'd0);
    check("disabled_no_ps", 32'(cnt[4]), 32'd0);
    bus_op(1'b0, 4'd5, 32'h0, 32'h0);
    bus_op(1'b0, 4'd2, 32'h0, 32'hA);
    bus_op(1'b0, 4'd0, 32'h0, 32'h0);

    // Reset while a response is pending and PWM is running
    bus_op(1'b1, 4'd1, 32'h0, 32'h0);
    bus_op(1'b1, 4'd3, 32'h0000_0080, 32'h0);
    bus_op(1'b1, 4'd2, 32'hF, 32'h0);
    bus_op(1'b1, 4'd0, 32'h1, 32'h0);
    repeat (100) @(negedge sys_clk);
    check("pre_reset_leds", 32'(leds), 32'hF);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd2;
    @(posedge sys_clk);
    #2;
    check("rsp_pending", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    req_valid = 1'b0;
    tb_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    foreach (addrs[i]) bus_op(1'b0, addrs[i], 32'h0, 32'h0);
    @(negedge sys_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
